// File: rtl/neuron_act.sv
// neuron_act: bias add with saturation, then identity / ReLU / sigmoid / hard-tanh, 3-stage stallable pipeline.
// Define NEURON_ACT_SIGMOID_EN to build the piecewise-linear sigmoid; otherwise act_sel 10 passes s through.
module neuron_act #(
    parameter int WIDTH = 16,
    parameter int Q     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_acc,
    input  logic [WIDTH-1:0] in_bias,
    input  logic [1:0]       in_act_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat_flag,
    output logic [CNT_W-1:0] out_count
);

    localparam logic signed [WIDTH-1:0] MAX_V   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_V   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1 << Q);
    localparam logic signed [WIDTH-1:0] NEG_ONE = -ONE;

    function automatic logic sum_ovf(input logic signed [WIDTH:0] v);
        return v[WIDTH] != v[WIDTH-1];
    endfunction

    function automatic logic signed [WIDTH-1:0] sat_sum(input logic signed [WIDTH:0] v);
        if (!sum_ovf(v))
            return v[WIDTH-1:0];
        return v[WIDTH] ? MIN_V : MAX_V;
    endfunction

    function automatic logic signed [WIDTH-1:0] hard_tanh(input logic signed [WIDTH-1:0] v);
        if (v > ONE)
            return ONE;
        if (v < NEG_ONE)
            return NEG_ONE;
        return v;
    endfunction

`ifdef NEURON_ACT_SIGMOID_EN
    localparam logic [WIDTH-1:0] SEG1  = WIDTH'(1 << Q);
    localparam logic [WIDTH-1:0] SEG2  = WIDTH'((19 << Q) >> 3);
    localparam logic [WIDTH-1:0] SEG3  = WIDTH'(5 << Q);
    localparam logic [WIDTH-1:0] HALF  = WIDTH'(1 << (Q - 1));
    localparam logic [WIDTH-1:0] OFS1  = WIDTH'(5 << (Q - 3));
    localparam logic [WIDTH-1:0] OFS2  = WIDTH'(27 << (Q - 5));
    localparam logic [WIDTH-1:0] ONE_U = WIDTH'(1 << Q);

    // The most negative value has no positive twin; clamp it to the largest magnitude.
    function automatic logic [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] v);
        if (v == MIN_V)
            return MAX_V;
        return v[WIDTH-1] ? WIDTH'(-v) : v;
    endfunction

    function automatic logic [1:0] seg_of(input logic [WIDTH-1:0] a);
        if (a < SEG1) return 2'd0;
        if (a < SEG2) return 2'd1;
        if (a < SEG3) return 2'd2;
        return 2'd3;
    endfunction

    function automatic logic signed [WIDTH-1:0] sigmoid(input logic [WIDTH-1:0] a,
                                                        input logic [1:0] seg,
                                                        input logic neg);
        logic [WIDTH-1:0] y;
        case (seg)
            2'd0:    y = (a >> 2) + HALF;
            2'd1:    y = (a >> 3) + OFS1;
            2'd2:    y = (a >> 5) + OFS2;
            default: y = ONE_U;
        endcase
        if (neg)
            y = ONE_U - y;
        return $signed(y);
    endfunction
`endif

    logic                    advance;
    logic signed [WIDTH:0]   sum_w;

    logic signed [WIDTH-1:0] s_p0;
    logic [1:0]              sel_p0;
    logic                    vld_p0;

    logic signed [WIDTH-1:0] s_p1;
    logic [1:0]              sel_p1;
    logic                    vld_p1;
`ifdef NEURON_ACT_SIGMOID_EN
    logic [WIDTH-1:0]        ax_p1;
    logic [1:0]              seg_p1;
`endif

    logic signed [WIDTH-1:0] y_p2;
    logic                    vld_p2;
    logic signed [WIDTH-1:0] y_nx;

    assign advance   = !vld_p2 || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_p2;
    assign out_data  = y_p2;
    assign sum_w     = {in_acc[WIDTH-1], in_acc} + {in_bias[WIDTH-1], in_bias};

    // Stage p0 -> p1 data path (held when stalled)
    always_ff @(posedge clk) begin
        if (advance) begin
            s_p0   <= sat_sum(sum_w);
            sel_p0 <= in_act_sel;
            s_p1   <= s_p0;
            sel_p1 <= sel_p0;
`ifdef NEURON_ACT_SIGMOID_EN
            ax_p1  <= abs_sat(s_p0);
            seg_p1 <= seg_of(abs_sat(s_p0));
`endif
        end
    end

    // Stage p2: activation select
    always_comb begin
        y_nx = s_p1;
        case (sel_p1)
            2'b01:   y_nx = s_p1[WIDTH-1] ? '0 : s_p1;
`ifdef NEURON_ACT_SIGMOID_EN
            2'b10:   y_nx = sigmoid(ax_p1, seg_p1, s_p1[WIDTH-1]);
`endif
            2'b11:   y_nx = hard_tanh(s_p1);
            default: y_nx = s_p1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p0    <= 1'b0;
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            y_p2      <= '0;
            sat_flag  <= 1'b0;
            out_count <= '0;
        end else begin
            if (advance) begin
                vld_p0 <= in_valid;
                vld_p1 <= vld_p0;
                vld_p2 <= vld_p1;
                if (vld_p1)
                    y_p2 <= y_nx;
                if (in_valid && sum_ovf(sum_w))
                    sat_flag <= 1'b1;
            end
            if (vld_p2 && out_ready)
                out_count <= out_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_neuron_act.sv
// Directed self-checking bench for neuron_act; sigmoid expectations follow NEURON_ACT_SIGMOID_EN.
module tb_neuron_act;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in_acc;
    logic [15:0] in_bias;
    logic [1:0]  in_act_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        sat_flag;
    logic [7:0]  out_count;

    int n_cmp = 0;
    int n_bad = 0;

    neuron_act #(.WIDTH(16), .Q(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_acc(in_acc), .in_bias(in_bias), .in_act_sel(in_act_sel),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sat_flag(sat_flag), .out_count(out_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Sends one input from an idle pipeline and captures the result; data is X on timeout.
    task automatic run_one(input logic [15:0] acc, input logic [15:0] bias, input logic [1:0] sel,
                           output logic [15:0] data, output int lat);
        in_acc = acc; in_bias = bias; in_act_sel = sel; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
        data = out_valid ? out_data : 16'hxxxx;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (out_valid !== 1'b0)   begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 16'h0)   begin n_bad++; $display("FAIL reset_data got %h want 0000", out_data); end
        n_cmp++; if (sat_flag !== 1'b0)    begin n_bad++; $display("FAIL reset_sat got %b want 0", sat_flag); end
        n_cmp++; if (out_count !== 8'd0)   begin n_bad++; $display("FAIL reset_count got %0d want 0", out_count); end
        n_cmp++; if (in_ready !== 1'b1)    begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_bias_add();
        logic [15:0] d; int lat;
        do_reset();
        run_one(16'h0180, 16'h0080, 2'b00, d, lat);
        n_cmp++; if (d !== 16'h0200)     begin n_bad++; $display("FAIL bias_add_data got %h want 0200", d); end
        n_cmp++; if (lat !== 3)          begin n_bad++; $display("FAIL bias_add_latency got %0d want 3", lat); end
        n_cmp++; if (sat_flag !== 1'b0)  begin n_bad++; $display("FAIL bias_add_sat got %b want 0", sat_flag); end
        n_cmp++; if (out_count !== 8'd1) begin n_bad++; $display("FAIL bias_add_count got %0d want 1", out_count); end
    endtask

    task automatic test_saturation();
        logic [15:0] d; int lat;
        do_reset();
        run_one(16'h7F00, 16'h0200, 2'b00, d, lat);
        n_cmp++; if (d !== 16'h7FFF)     begin n_bad++; $display("FAIL sat_pos got %h want 7fff", d); end
        n_cmp++; if (sat_flag !== 1'b1)  begin n_bad++; $display("FAIL sat_flag_set got %b want 1", sat_flag); end
        run_one(16'h8100, 16'hFE00, 2'b00, d, lat);
        n_cmp++; if (d !== 16'h8000)     begin n_bad++; $display("FAIL sat_neg got %h want 8000", d); end
        run_one(16'h0100, 16'h0000, 2'b00, d, lat);
        n_cmp++; if (d !== 16'h0100)     begin n_bad++; $display("FAIL sat_after_data got %h want 0100", d); end
        n_cmp++; if (sat_flag !== 1'b1)  begin n_bad++; $display("FAIL sat_sticky got %b want 1", sat_flag); end
        n_cmp++; if (out_count !== 8'd3) begin n_bad++; $display("FAIL sat_count got %0d want 3", out_count); end
    endtask

    task automatic test_relu_htanh();
        logic [15:0] acc_v [4] = '{16'hFF00, 16'h0300, 16'h0300, 16'hFD00};
        logic [1:0]  sel_v [4] = '{2'b01, 2'b01, 2'b11, 2'b11};
        logic [15:0] exp_v [4] = '{16'h0000, 16'h0300, 16'h0100, 16'hFF00};
        logic [15:0] d; int lat;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            run_one(acc_v[i], 16'h0000, sel_v[i], d, lat);
            n_cmp++;
            if (d !== exp_v[i]) begin
                n_bad++; $display("FAIL relu_htanh[%0d] got %h want %h", i, d, exp_v[i]);
            end
        end
    endtask

    task automatic test_sigmoid();
        logic [15:0] x_v   [6] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0600, 16'h8000, 16'h0300};
`ifdef NEURON_ACT_SIGMOID_EN
        logic [15:0] exp_v [6] = '{16'h0080, 16'h00C0, 16'h0040, 16'h0100, 16'h0000, 16'h00F0};
`else
        logic [15:0] exp_v [6] = '{16'h0000, 16'h0100, 16'hFF00, 16'h0600, 16'h8000, 16'h0300};
`endif
        logic [15:0] d; int lat;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            run_one(x_v[i], 16'h0000, 2'b10, d, lat);
            n_cmp++;
            if (d !== exp_v[i]) begin
                n_bad++; $display("FAIL sigmoid[%0d] x=%h got %h want %h", i, x_v[i], d, exp_v[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got [$];
        int sent = 0;
        int stalls = 0;
        int ready_bad = 0;
        do_reset();
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_ready  = !(cyc >= 4 && cyc <= 8);
            in_valid   = (sent < 6);
            in_acc     = 16'((sent + 1) * 16'h0010);
            in_bias    = 16'h0000;
            in_act_sel = 2'b00;
            #1;
            if (in_ready !== !(out_valid && !out_ready)) ready_bad++;
            if (out_valid && !out_ready) stalls++;
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_cmp++; if (ready_bad != 0)   begin n_bad++; $display("FAIL bp_in_ready wrong in %0d cycles want 0", ready_bad); end
        n_cmp++; if (stalls != 5)      begin n_bad++; $display("FAIL bp_stall_cycles got %0d want 5", stalls); end
        n_cmp++; if (got.size() != 6)  begin n_bad++; $display("FAIL bp_result_count got %0d want 6", got.size()); end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== 16'((i + 1) * 16'h0010)) begin
                n_bad++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], 16'((i + 1) * 16'h0010));
            end
        end
        n_cmp++; if (out_count !== 8'd6) begin n_bad++; $display("FAIL bp_out_count got %0d want 6", out_count); end
    endtask

    task automatic test_reset_mid();
        int emitted = 0;
        do_reset();
        out_ready = 1'b1; in_act_sel = 2'b00;
        in_acc = 16'h7F00; in_bias = 16'h0200; in_valid = 1'b1;
        @(posedge clk); #1;
        in_acc = 16'h0040; in_bias = 16'h0000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (sat_flag !== 1'b1)  begin n_bad++; $display("FAIL mid_sat_before got %b want 1", sat_flag); end
        do_reset();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_valid got %b want 0", out_valid); end
        n_cmp++; if (out_count !== 8'd0) begin n_bad++; $display("FAIL mid_count got %0d want 0", out_count); end
        n_cmp++; if (sat_flag !== 1'b0)  begin n_bad++; $display("FAIL mid_sat got %b want 0", sat_flag); end
        for (int i = 0; i < 8; i++) begin
            if (out_valid) emitted++;
            @(posedge clk); #1;
        end
        n_cmp++; if (emitted != 0)       begin n_bad++; $display("FAIL mid_discard got %0d results want 0", emitted); end
    endtask

    initial begin
        reset = 1'b0; in_acc = '0; in_bias = '0; in_act_sel = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_bias_add();
        test_saturation();
        test_relu_htanh();
        test_sigmoid();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
